// File: rtl/execute_stage_pkg.sv
// Shared encodings for decode, regE and execute: ALU function, operand selects,
// mul/div opcodes and the mul/div FSM state.
package execute_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_func_e;

    typedef enum logic [1:0] {
        A_SEL_VALA = 2'd0,
        A_SEL_PC   = 2'd1,
        A_SEL_ZERO = 2'd2
    } alu_a_sel_e;

    typedef enum logic [1:0] {
        B_SEL_VALB = 2'd0,
        B_SEL_IMM  = 2'd1,
        B_SEL_FOUR = 2'd2
    } alu_b_sel_e;

    typedef enum logic [3:0] {
        MD_NONE   = 4'd0,
        MD_MUL    = 4'd1,
        MD_MULH   = 4'd2,
        MD_MULHSU = 4'd3,
        MD_MULHU  = 4'd4,
        MD_DIV    = 4'd5,
        MD_DIVU   = 4'd6,
        MD_REM    = 4'd7,
        MD_REMU   = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Any of the four division-family ops (quotient or remainder).
    function automatic logic is_div_op(md_op_e op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic is_rem_op(md_op_e op);
        return op inside {MD_REM, MD_REMU};
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// regE/ctrl -> execute bundle. Handshake: stall high means regE must hold its
// operands and op; the result on valE is consumed in any cycle where stall is low.
interface execute_stage_if #(parameter int XLEN = 32);
    import execute_stage_pkg::*;

    logic [XLEN-1:0] regE_i_valA;
    logic [XLEN-1:0] regE_i_valB;
    logic [XLEN-1:0] regE_i_imm;
    logic [XLEN-1:0] regE_i_pc;
    logic [1:0]      regE_i_alu_valA_sel;
    logic [1:0]      regE_i_alu_valB_sel;
    logic [3:0]      regE_i_alu_func_sel;
    logic [3:0]      regE_i_md_op;
    logic            ctrl_i_execute_flush;
    logic [XLEN-1:0] execute_o_valE;
    logic            execute_o_stall;
    logic            execute_o_md_busy;
    md_state_e       execute_o_md_state;

    modport master (
        output regE_i_valA, regE_i_valB, regE_i_imm, regE_i_pc,
        output regE_i_alu_valA_sel, regE_i_alu_valB_sel,
        output regE_i_alu_func_sel, regE_i_md_op, ctrl_i_execute_flush,
        input  execute_o_valE, execute_o_stall, execute_o_md_busy, execute_o_md_state
    );

    modport slave (
        input  regE_i_valA, regE_i_valB, regE_i_imm, regE_i_pc,
        input  regE_i_alu_valA_sel, regE_i_alu_valB_sel,
        input  regE_i_alu_func_sel, regE_i_md_op, ctrl_i_execute_flush,
        output execute_o_valE, execute_o_stall, execute_o_md_busy, execute_o_md_state
    );
endinterface

// File: rtl/execute_muldiv.sv
// Iterative multiply/divide unit (IDLE/BUSY/DONE). Define EXECUTE_FAST_MUL_EN to
// complete multiplies in a single cycle; division is always one bit per cycle.
module execute_muldiv
    import execute_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MD_ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      md_op_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output md_state_e       state_o
);
    localparam int CW = $clog2(MD_ITER + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MD_ITER - 1);

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   result_q, result_d;
    md_op_e            op_q, op_d;
    logic              neg_q, neg_d;

    md_op_e            op_in;
    logic              a_neg, b_neg, div_zero, div_ovf, neg_in;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, rem_sh, div_diff;
    logic [2*XLEN-1:0] acc_step;

    assign op_in = md_op_e'(md_op_i);

    // Magnitudes and sign fixups; low-half mul is sign-agnostic so it runs unsigned.
    always_comb begin
        a_neg    = (op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) && op_a_i[XLEN-1];
        b_neg    = (op_in inside {MD_MULH, MD_DIV, MD_REM}) && op_b_i[XLEN-1];
        a_mag    = a_neg ? -op_a_i : op_a_i;
        b_mag    = b_neg ? -op_b_i : op_b_i;
        div_zero = is_div_op(op_in) && (op_b_i == '0);
        div_ovf  = (op_in inside {MD_DIV, MD_REM}) &&
                   (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b_i);
        neg_in   = is_rem_op(op_in) ? a_neg : (a_neg ^ b_neg);
    end

`ifdef EXECUTE_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    // acc holds {product_hi, multiplier} for mul and {remainder, quotient} for div.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        div_diff = rem_sh - {1'b0, opb_q};
        if (is_div_op(op_q)) begin
            acc_step = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    function automatic logic [XLEN-1:0] finalize(md_op_e op, logic neg, logic [2*XLEN-1:0] acc);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo, rem, res;
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op)
            MD_MUL:                        res = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  res = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               res = quo;
            default:                       res = rem;
        endcase
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        stall_o  = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (op_in != MD_NONE && !flush_i) begin
                    stall_o = 1'b1;
                    op_d    = op_in;
                    neg_d   = neg_in;
                    cnt_d   = '0;
                    if (div_zero) begin
                        result_d = is_rem_op(op_in) ? op_a_i : '1;
                        state_d  = MD_DONE;
                    end else if (div_ovf) begin
                        result_d = is_rem_op(op_in) ? '0 : op_a_i;
                        state_d  = MD_DONE;
                    end
`ifdef EXECUTE_FAST_MUL_EN
                    else if (!is_div_op(op_in)) begin
                        result_d = finalize(op_in, neg_in, fast_prod);
                        state_d  = MD_DONE;
                    end
`endif
                    else begin
                        acc_d   = is_div_op(op_in) ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                        opb_d   = is_div_op(op_in) ? b_mag : a_mag;
                        state_d = MD_BUSY;
                    end
                end
            end
            MD_BUSY: begin
                stall_o = 1'b1;
                busy_o  = 1'b1;
                acc_d   = acc_step;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    result_d = finalize(op_q, neg_q, acc_step);
                    state_d  = MD_DONE;
                end
            end
            MD_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        if (flush_i) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
            stall_o = 1'b0;
            done_o  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            op_q     <= MD_NONE;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
        end
    end

    assign result_o = result_q;
    assign state_o  = state_q;
endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand muxes and single-cycle ALU, plus the mul/div unit whose
// DONE-cycle result overrides the ALU on valE. Honours EXECUTE_FAST_MUL_EN via execute_muldiv.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MD_ITER = 32
) (
    input logic                clk,
    input logic                rst,
    execute_stage_if.slave     bus
);
    logic [XLEN-1:0] op_a, op_b, alu_res, md_result;
    logic [4:0]      shamt;
    logic            md_stall, md_busy, md_done;
    md_state_e       md_state;

    always_comb begin
        case (alu_a_sel_e'(bus.regE_i_alu_valA_sel))
            A_SEL_VALA: op_a = bus.regE_i_valA;
            A_SEL_PC:   op_a = bus.regE_i_pc;
            default:    op_a = '0;
        endcase
        case (alu_b_sel_e'(bus.regE_i_alu_valB_sel))
            B_SEL_VALB: op_b = bus.regE_i_valB;
            B_SEL_IMM:  op_b = bus.regE_i_imm;
            default:    op_b = XLEN'(4);
        endcase
    end

    assign shamt = op_b[4:0];

    always_comb begin
        case (alu_func_e'(bus.regE_i_alu_func_sel))
            ALU_ADD:   alu_res = op_a + op_b;
            ALU_SUB:   alu_res = op_a - op_b;
            ALU_AND:   alu_res = op_a & op_b;
            ALU_OR:    alu_res = op_a | op_b;
            ALU_XOR:   alu_res = op_a ^ op_b;
            ALU_SLL:   alu_res = op_a << shamt;
            ALU_SRL:   alu_res = op_a >> shamt;
            ALU_SRA:   alu_res = $signed(op_a) >>> shamt;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_PASSB: alu_res = op_b;
            default:   alu_res = '0;
        endcase
    end

    execute_muldiv #(.XLEN(XLEN), .MD_ITER(MD_ITER)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .md_op_i  (bus.regE_i_md_op),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .flush_i  (bus.ctrl_i_execute_flush),
        .stall_o  (md_stall),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result),
        .state_o  (md_state)
    );

    assign bus.execute_o_valE     = md_done ? md_result : alu_res;
    assign bus.execute_o_stall    = md_stall;
    assign bus.execute_o_md_busy  = md_busy;
    assign bus.execute_o_md_state = md_state;
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: ALU vectors, mul/div latency and results,
// special-case divides, flush and mid-operation reset.
module tb_execute_stage;
    import execute_stage_pkg::*;

    localparam int MD_ITER = 32;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];

    execute_stage_if #(.XLEN(32)) bus ();

    execute_stage #(.XLEN(32), .MD_ITER(MD_ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference models ----------------
    function automatic logic [31:0] ref_alu(alu_func_e f, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        case (f)
            ALU_ADD:   r = a + b;
            ALU_SUB:   r = a - b;
            ALU_AND:   r = a & b;
            ALU_OR:    r = a | b;
            ALU_XOR:   r = a ^ b;
            ALU_SLL:   r = a << b[4:0];
            ALU_SRL:   r = a >> b[4:0];
            ALU_SRA:   r = $signed(a) >>> b[4:0];
            ALU_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
            ALU_PASSB: r = b;
            default:   r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ref_md(md_op_e op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, ua, ub, q;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        r  = 32'd0;
        case (op)
            MD_MUL:    begin p = ua * ub; r = p[31:0];  end
            MD_MULH:   begin p = sa * sb; r = p[63:32]; end
            MD_MULHSU: begin p = sa * ub; r = p[63:32]; end
            MD_MULHU:  begin p = ua * ub; r = p[63:32]; end
            MD_DIV:    begin if (b == 0) r = 32'hFFFF_FFFF; else begin q = sa / sb; r = q[31:0]; end end
            MD_DIVU:   begin if (b == 0) r = 32'hFFFF_FFFF; else begin q = ua / ub; r = q[31:0]; end end
            MD_REM:    begin if (b == 0) r = a; else begin q = sa % sb; r = q[31:0]; end end
            MD_REMU:   begin if (b == 0) r = a; else begin q = ua % ub; r = q[31:0]; end end
            default:   r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic int exp_stall(md_op_e op, logic [31:0] a, logic [31:0] b);
        if (is_div_op(op) && b == 32'd0) return 1;
        if ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef EXECUTE_FAST_MUL_EN
        if (!is_div_op(op)) return 1;
`endif
        return 1 + MD_ITER;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(alu_func_e f, alu_a_sel_e asel, alu_b_sel_e bsel,
                         logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                         logic [31:0] pc, md_op_e op);
        bus.regE_i_alu_func_sel = f;
        bus.regE_i_alu_valA_sel = asel;
        bus.regE_i_alu_valB_sel = bsel;
        bus.regE_i_valA         = a;
        bus.regE_i_valB         = b;
        bus.regE_i_imm          = imm;
        bus.regE_i_pc           = pc;
        bus.regE_i_md_op        = op;
    endtask

    // Issues one mul/div op and waits (bounded) for stall to drop; returns what it saw in the DONE cycle.
    task automatic issue_md(md_op_e op, logic [31:0] a, logic [31:0] b,
                            output int n_stall, output logic [31:0] val,
                            output logic busy, output logic timed_out);
        @(posedge clk); #1;
        drive(ALU_ADD, A_SEL_VALA, B_SEL_VALB, a, b, 32'd0, 32'd0, op);
        n_stall = 0;
        @(negedge clk);
        while (bus.execute_o_stall === 1'b1 && n_stall < 200) begin
            n_stall++;
            @(negedge clk);
        end
        timed_out = (n_stall >= 200);
        val  = bus.execute_o_valE;
        busy = bus.execute_o_md_busy;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.ctrl_i_execute_flush = 1'b0;
        drive(ALU_ADD, A_SEL_VALA, B_SEL_VALB, 32'd3, 32'd4, 32'd0, 32'd0, MD_NONE);
        @(negedge clk);
        checks++;
        if (bus.execute_o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.execute_o_stall); end
        checks++;
        if (bus.execute_o_md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.execute_o_md_busy); end
        checks++;
        if (bus.execute_o_md_state !== MD_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", bus.execute_o_md_state, MD_IDLE); end
        checks++;
        if (bus.execute_o_valE !== 32'd7) begin errors++; $display("FAIL reset_valE: got %h want 00000007", bus.execute_o_valE); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        alu_func_e   f;
        alu_a_sel_e  asel;
        alu_b_sel_e  bsel;
        logic [31:0] a, b, imm, pc, expv;
    } alu_vec_t;

    task automatic test_alu();
        alu_vec_t av [0:12];
        logic [31:0] e;
        av = '{
            '{ALU_ADD,   A_SEL_VALA, B_SEL_IMM,  32'd5,         32'd0,         32'hFFFF_FFF9, 32'd0,    32'hFFFF_FFFE},
            '{ALU_SUB,   A_SEL_VALA, B_SEL_VALB, 32'd3,         32'd5,         32'd0,         32'd0,    32'hFFFF_FFFE},
            '{ALU_AND,   A_SEL_VALA, B_SEL_VALB, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0,         32'd0,    32'h00F0_00F0},
            '{ALU_OR,    A_SEL_VALA, B_SEL_VALB, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0,         32'd0,    32'hFFF0_FFF0},
            '{ALU_XOR,   A_SEL_VALA, B_SEL_VALB, 32'hFFFF_FFFF, 32'h1234_5678, 32'd0,         32'd0,    32'hEDCB_A987},
            '{ALU_SLL,   A_SEL_VALA, B_SEL_VALB, 32'd1,         32'h0000_003F, 32'd0,         32'd0,    32'h8000_0000},
            '{ALU_SRL,   A_SEL_VALA, B_SEL_VALB, 32'h8000_0000, 32'd4,         32'd0,         32'd0,    32'h0800_0000},
            '{ALU_SRA,   A_SEL_VALA, B_SEL_VALB, 32'h8000_0000, 32'd4,         32'd0,         32'd0,    32'hF800_0000},
            '{ALU_SLT,   A_SEL_VALA, B_SEL_VALB, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0,    32'd1},
            '{ALU_SLTU,  A_SEL_VALA, B_SEL_VALB, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0,    32'd0},
            '{ALU_PASSB, A_SEL_ZERO, B_SEL_VALB, 32'd9,         32'hDEAD_BEEF, 32'd0,         32'd0,    32'hDEAD_BEEF},
            '{ALU_ADD,   A_SEL_PC,   B_SEL_FOUR, 32'd9,         32'd9,         32'd0,         32'h1000, 32'h0000_1004},
            '{ALU_ADD,   A_SEL_ZERO, B_SEL_IMM,  32'd9,         32'd9,         32'h123,       32'd0,    32'h0000_0123}
        };
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            drive(av[i].f, av[i].asel, av[i].bsel, av[i].a, av[i].b, av[i].imm, av[i].pc, MD_NONE);
            exp_q.push_back(av[i].expv);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (bus.execute_o_valE !== e) begin errors++; $display("FAIL alu_vec%0d: got %h want %h", i, bus.execute_o_valE, e); end
            checks++;
            if (bus.execute_o_stall !== 1'b0) begin errors++; $display("FAIL alu_stall%0d: got %b want 0", i, bus.execute_o_stall); end
        end
        for (int i = 0; i < 12; i++) begin
            alu_func_e   f;
            logic [31:0] a, b;
            f = alu_func_e'(4'($urandom_range(0, 10)));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            @(posedge clk); #1;
            drive(f, A_SEL_VALA, B_SEL_VALB, a, b, 32'd0, 32'd0, MD_NONE);
            exp_q.push_back(ref_alu(f, a, b));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (bus.execute_o_valE !== e) begin errors++; $display("FAIL alu_rand f=%0d a=%h b=%h: got %h want %h", f, a, b, bus.execute_o_valE, e); end
        end
    endtask

    typedef struct {
        md_op_e      op;
        logic [31:0] a, b, expv;
    } md_vec_t;

    task automatic check_md(string tag, md_op_e op, logic [31:0] a, logic [31:0] b, logic [31:0] expv);
        int n; logic [31:0] v, e; logic busy, to;
        exp_q.push_back(expv);
        issue_md(op, a, b, n, v, busy, to);
        e = exp_q.pop_front();
        checks++;
        if (to) begin errors++; $display("FAIL %s_timeout: stall never dropped, got %0d cycles", tag, n); end
        checks++;
        if (n != exp_stall(op, a, b)) begin errors++; $display("FAIL %s_stall_cycles: got %0d want %0d", tag, n, exp_stall(op, a, b)); end
        checks++;
        if (v !== e) begin errors++; $display("FAIL %s_result: got %h want %h", tag, v, e); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s_done_busy: got %b want 1", tag, busy); end
    endtask

    task automatic test_muldiv();
        md_vec_t mv [0:13];
        mv = '{
            '{MD_DIV,    32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2},
            '{MD_REM,    32'd100,       32'hFFFF_FFF9, 32'h0000_0002},
            '{MD_DIVU,   32'd1234,      32'd0,         32'hFFFF_FFFF},
            '{MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
            '{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{MD_MUL,    32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB},
            '{MD_MULH,   32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF},
            '{MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
            '{MD_MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000},
            '{MD_REMU,   32'd1000,      32'd7,         32'h0000_0006},
            '{MD_REM,    32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C},
            '{MD_DIV,    32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2},
            '{MD_DIVU,   32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF}
        };
        for (int i = 0; i < 14; i++)
            check_md($sformatf("md_vec%0d", i), mv[i].op, mv[i].a, mv[i].b, mv[i].expv);
        @(posedge clk); #1;
        bus.regE_i_md_op = MD_NONE;
        @(negedge clk);
        checks++;
        if (bus.execute_o_md_state !== MD_IDLE || bus.execute_o_md_busy !== 1'b0 || bus.execute_o_stall !== 1'b0) begin
            errors++;
            $display("FAIL md_after_done: got state=%0d busy=%b stall=%b want state=0 busy=0 stall=0",
                     bus.execute_o_md_state, bus.execute_o_md_busy, bus.execute_o_stall);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            md_op_e op; logic [31:0] a, b;
            op = md_op_e'(4'($urandom_range(1, 8)));
            a  = $urandom;
            b  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
            check_md($sformatf("b2b%0d", i), op, a, b, ref_md(op, a, b));
        end
        @(posedge clk); #1;
        bus.regE_i_md_op = MD_NONE;
    endtask

    task automatic test_flush();
        int busy_seen;
        @(posedge clk); #1;
        drive(ALU_ADD, A_SEL_VALA, B_SEL_VALB, 32'd100, 32'd7, 32'd0, 32'd0, MD_DIV);
        @(negedge clk);
        repeat (10) @(posedge clk);
        #1;
        bus.ctrl_i_execute_flush = 1'b1;
        bus.regE_i_md_op = MD_NONE;
        @(negedge clk);
        checks++;
        if (bus.execute_o_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", bus.execute_o_stall); end
        @(posedge clk); #1;
        bus.ctrl_i_execute_flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.execute_o_md_state !== MD_IDLE) begin errors++; $display("FAIL flush_idle: got %0d want %0d", bus.execute_o_md_state, MD_IDLE); end
        busy_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.execute_o_md_busy !== 1'b0) busy_seen++;
        end
        checks++;
        if (busy_seen != 0) begin errors++; $display("FAIL flush_no_done: got %0d busy cycles want 0", busy_seen); end
        // Flush arriving together with a new op keeps the unit idle.
        @(posedge clk); #1;
        bus.ctrl_i_execute_flush = 1'b1;
        bus.regE_i_md_op = MD_DIVU;
        @(negedge clk);
        checks++;
        if (bus.execute_o_stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b want 0", bus.execute_o_stall); end
        @(posedge clk); #1;
        bus.ctrl_i_execute_flush = 1'b0;
        bus.regE_i_md_op = MD_NONE;
        @(negedge clk);
        checks++;
        if (bus.execute_o_md_state !== MD_IDLE) begin errors++; $display("FAIL flush_suppress: got %0d want %0d", bus.execute_o_md_state, MD_IDLE); end
    endtask

    task automatic test_reset_busy();
        int busy_seen;
        @(posedge clk); #1;
        drive(ALU_ADD, A_SEL_VALA, B_SEL_VALB, 32'd1000, 32'd3, 32'd0, 32'd0, MD_DIVU);
        @(negedge clk);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.regE_i_md_op = MD_NONE;
        #1;
        checks++;
        if (bus.execute_o_md_state !== MD_IDLE || bus.execute_o_stall !== 1'b0 || bus.execute_o_md_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_async: got state=%0d stall=%b busy=%b want 0/0/0",
                     bus.execute_o_md_state, bus.execute_o_stall, bus.execute_o_md_busy);
        end
        checks++;
        if (bus.execute_o_valE !== 32'd1003) begin errors++; $display("FAIL rst_busy_valE: got %h want 000003eb", bus.execute_o_valE); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        busy_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.execute_o_md_busy !== 1'b0 || bus.execute_o_stall !== 1'b0) busy_seen++;
        end
        checks++;
        if (busy_seen != 0) begin errors++; $display("FAIL rst_busy_no_done: got %0d active cycles want 0", busy_seen); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_alu();
        test_muldiv();
        test_back_to_back();
        test_flush();
        test_reset_busy();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
